// File: rtl/bidir_bus_ctrl.sv
// Half-duplex bidirectional pad bus sequencer.
// Turns single-cycle core requests into setup/strobe/hold/turnaround pad cycles.
module bidir_bus_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETUP  = 1,
    parameter int STROBE = 2,
    parameter int TURN   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             ack,
    output logic [WIDTH-1:0] rdata,
    output logic             stb,
    output logic [WIDTH-1:0] pad_o,
    output logic [WIDTH-1:0] pad_t,
    input  logic [WIDTH-1:0] pad_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STRB,
        S_HOLD,
        S_TURN,
        S_DONE
    } state_t;

    // Counter reload values: count runs from N-1 down to 0.
    localparam logic [3:0] SETUP_LD = 4'(SETUP - 1);
    localparam logic [3:0] STRB_LD  = 4'(STROBE - 1);
    localparam logic [3:0] TURN_LD  = 4'(TURN - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic               cap;
    logic               drive_d;

    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic               stb_q, stb_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic [WIDTH-1:0]   pad_o_q, pad_o_d;
    logic [WIDTH-1:0]   pad_t_q, pad_t_d;

    // Next state, counter, request latch, and next values of the output registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        cap     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    wdata_d = wdata;
                    if (SETUP > 0) begin
                        state_d = S_SETUP;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = S_STRB;
                        cnt_d   = STRB_LD;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_STRB;
                    cnt_d   = STRB_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_STRB: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_HOLD;
                    cap     = !wr_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                state_d = S_TURN;
                cnt_d   = TURN_LD;
            end
            S_TURN: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pins are driven only in SETUP/STRB/HOLD of a write.
        drive_d = wr_d && ((state_d == S_SETUP) ||
                           (state_d == S_STRB)  ||
                           (state_d == S_HOLD));
        pad_t_d = drive_d ? '0 : '1;
        pad_o_d = drive_d ? wdata_d : '0;
        stb_d   = (state_d == S_STRB);
        ack_d   = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
        rdata_d = cap ? pad_i : rdata_q;
    end

    // State and registered outputs; reset releases the bus immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            stb_q   <= 1'b0;
            rdata_q <= '0;
            pad_o_q <= '0;
            pad_t_q <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            stb_q   <= stb_d;
            rdata_q <= rdata_d;
            pad_o_q <= pad_o_d;
            pad_t_q <= pad_t_d;
        end
    end

    assign busy  = busy_q;
    assign ack   = ack_q;
    assign stb   = stb_q;
    assign rdata = rdata_q;
    assign pad_o = pad_o_q;
    assign pad_t = pad_t_q;

endmodule
